// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI4 single-port RAM controller.
// Holds the burst and FSM encodings, the response codes and the legal-wrap-length helper.
package axi_ram_pkg;

    typedef enum logic [1:0] {
        FIXED    = 2'b00,
        INCR     = 2'b01,
        WRAP     = 2'b10,
        RESERVED = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        WRESP,
        RD
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // A WRAP burst needs a power-of-two beat count of 2, 4, 8 or 16.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/axi_ram_addr_gen.sv
// Combinational next-word-index generator for FIXED/INCR/WRAP bursts.
// The write path and the read path both use this block.
module axi_ram_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] idx,
    input  logic [7:0]    len,
    input  burst_e        burst,
    output logic [AW-1:0] next_idx
);

    logic [AW-1:0] incr_idx;
    logic [AW-1:0] wrap_mask;

    assign incr_idx  = idx + AW'(1);
    assign wrap_mask = AW'(len);

    always_comb begin
        case (burst)
            FIXED:   next_idx = idx;
            // The block base stays put; only the low bits covered by len roll over.
            WRAP:    next_idx = wrap_len_ok(len) ? ((idx & ~wrap_mask) | (incr_idx & wrap_mask))
                                                 : incr_idx;
            default: next_idx = incr_idx;
        endcase
    end

endmodule

// File: rtl/axi_ram_ctrl.sv
// AXI4 slave front end sequencing one word-addressed single-port RAM, one burst at a time.
// Optional AXI_RAM_OOR_ERR_EN: flag beats whose word index is >= RAM_DEPTH instead of aliasing.
module axi_ram_ctrl
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(NB);
    localparam int IDX_W = $clog2(RAM_DEPTH);

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [7:0]              len_q, len_d;
    burst_e                  burst_q, burst_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    wr_prio_q, wr_prio_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic                    rd_done_q, rd_done_d;

    logic [ADDR_WIDTH-1:0]   next_idx;
    logic                    oor;
    logic                    aw_hs, ar_hs, w_hs, r_fire;
    logic                    last_beat, beat_err;

`ifdef AXI_RAM_OOR_ERR_EN
    function automatic logic [ADDR_WIDTH-1:0] fit_idx(input logic [ADDR_WIDTH-1:0] x);
        return x;
    endfunction

    assign oor = (idx_q >> IDX_W) != '0;
`else
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK = ADDR_WIDTH'((64'd1 << IDX_W) - 64'd1);

    // Without range checking the index simply aliases onto the RAM.
    function automatic logic [ADDR_WIDTH-1:0] fit_idx(input logic [ADDR_WIDTH-1:0] x);
        return x & IDX_MASK;
    endfunction

    assign oor = 1'b0;
`endif

    function automatic logic [ADDR_WIDTH-1:0] to_idx(input logic [ADDR_WIDTH-1:0] addr);
        return fit_idx(addr >> OFFS);
    endfunction

    axi_ram_addr_gen #(
        .AW (ADDR_WIDTH)
    ) u_addr_gen (
        .idx      (idx_q),
        .len      (len_q),
        .burst    (burst_q),
        .next_idx (next_idx)
    );

    // Round-robin only matters when both address channels request in the same cycle.
    assign awready = !rst && (state_q == IDLE) && awvalid && (wr_prio_q || !arvalid);
    assign arready = !rst && (state_q == IDLE) && arvalid && (!wr_prio_q || !awvalid);

    assign aw_hs     = awvalid && awready;
    assign ar_hs     = arvalid && arready;
    assign w_hs      = (state_q == WR) && wvalid && wready_q;
    assign r_fire    = (state_q == RD) && !rd_done_q && (!rvalid_q || rready);
    assign last_beat = (cnt_q == len_q);
    assign beat_err  = !(&wstrb) || (wlast != last_beat) || oor;

    assign ram_en    = (w_hs || r_fire) && !oor;
    assign ram_we    = w_hs && !oor && (&wstrb);
    assign ram_addr  = idx_q;
    assign ram_wdata = wdata;

    assign wready = wready_q;
    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign bid    = id_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rid    = id_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d   = state_q;
        id_d      = id_q;
        idx_d     = idx_q;
        len_d     = len_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wr_prio_d = wr_prio_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_done_d = rd_done_q;

        case (state_q)
            IDLE: begin
                if (awvalid && arvalid) begin
                    wr_prio_d = !wr_prio_q;
                end
                if (aw_hs) begin
                    id_d     = awid;
                    idx_d    = to_idx(awaddr);
                    len_d    = awlen;
                    burst_d  = burst_e'(awburst);
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    wready_d = 1'b1;
                    state_d  = WR;
                end else if (ar_hs) begin
                    id_d      = arid;
                    idx_d     = to_idx(araddr);
                    len_d     = arlen;
                    burst_d   = burst_e'(arburst);
                    cnt_d     = '0;
                    rd_done_d = 1'b0;
                    state_d   = RD;
                end
            end
            WR: begin
                if (w_hs) begin
                    err_d = err_q || beat_err;
                    idx_d = fit_idx(next_idx);
                    cnt_d = cnt_q + 8'd1;
                    // The beat count, not wlast, closes the burst.
                    if (last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q || beat_err) ? SLVERR : OKAY;
                        state_d  = WRESP;
                    end
                end
            end
            WRESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD: begin
                if (r_fire) begin
                    rvalid_d = 1'b1;
                    rlast_d  = last_beat;
                    rdata_d  = oor ? '0 : ram_rdata;
                    rresp_d  = oor ? SLVERR : OKAY;
                    idx_d    = fit_idx(next_idx);
                    cnt_d    = cnt_q + 8'd1;
                    if (last_beat) begin
                        rd_done_d = 1'b1;
                    end
                end else if (rvalid_q && rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            burst_q   <= FIXED;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_prio_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_prio_q <= wr_prio_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rd_done_q <= rd_done_d;
        end
    end

endmodule

// File: tb/tb_axi_ram_ctrl.sv
// Scoreboard bench for axi_ram_ctrl: a behavioural RAM, a reference memory model and
// queues of expected RAM accesses, R beats and B responses.
module tb_axi_ram_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;
    logic        rlast, rvalid, rready;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } ram_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

    ram_exp_t    ram_q[$];
    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    logic [31:0] mem   [0:255];
    logic [31:0] model [0:255];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        hold_pend;
    logic [63:0] hold_val;

    axi_ram_ctrl dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[7:0]];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fit(input logic [31:0] x);
`ifdef AXI_RAM_OOR_ERR_EN
        return x;
`else
        return x % 32'd256;
`endif
    endfunction

    function automatic bit is_oor(input logic [31:0] idx);
`ifdef AXI_RAM_OOR_ERR_EN
        return idx >= 32'd256;
`else
        return (idx > 32'd255) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] idx, input int len, input logic [1:0] burst);
        logic [31:0] sz, base;
        sz = 32'(len + 1);
        if (burst == 2'b00) return idx;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            base = idx - (idx % sz);
            return base + ((idx - base + 32'd1) % sz);
        end
        return fit(idx + 32'd1);
    endfunction

    function automatic logic beat_last(input int i, input int len, input int last_at);
        return (last_at >= 0) ? (i == last_at) : (i == len);
    endfunction

    task automatic exp_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [31:0] base,
                             input int bad_strb, input int last_at);
        logic [31:0] idx;
        bit          err;
        ram_exp_t    e;
        b_exp_t      b;
        idx = fit(addr >> 2);
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bit good;
            good = (i != bad_strb);
            if (!good || beat_last(i, len, last_at) != (i == len) || is_oor(idx)) err = 1'b1;
            if (!is_oor(idx)) begin
                e.addr = idx; e.we = good; e.wdata = base + 32'(i);
                ram_q.push_back(e);
                if (good) model[idx[7:0]] = base + 32'(i);
            end
            idx = nxt(idx, len, burst);
        end
        b.id = id; b.resp = err ? 2'b10 : 2'b00;
        b_q.push_back(b);
    endtask

    task automatic exp_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
        logic [31:0] idx;
        ram_exp_t    e;
        r_exp_t      r;
        idx = fit(addr >> 2);
        for (int i = 0; i <= len; i++) begin
            r.id = id; r.last = (i == len);
            if (is_oor(idx)) begin
                r.data = 32'd0; r.resp = 2'b10;
            end else begin
                r.data = model[idx[7:0]]; r.resp = 2'b00;
                e.addr = idx; e.we = 1'b0; e.wdata = 32'd0;
                ram_q.push_back(e);
            end
            r_q.push_back(r);
            idx = nxt(idx, len, burst);
        end
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        int n;
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 100);
        check("aw_handshake", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        int n;
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 100);
        check("ar_handshake", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic w_phase(input int len, input logic [31:0] base, input int bad_strb, input int last_at);
        int n;
        for (int i = 0; i <= len; i++) begin
            wdata = base + 32'(i);
            wstrb = (i == bad_strb) ? 4'h7 : 4'hF;
            wlast = beat_last(i, len, last_at);
            wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 100);
            check("w_handshake", wready, 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; wstrb = 4'hF;
    endtask

    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while ((ram_q.size() != 0 || r_q.size() != 0 || b_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            if (toggle) rready = ~rready;
            else        rready = 1'b1;
            n++;
        end
        rready = 1'b1;
        check("drain_in_budget", n < 200, 1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [31:0] base, input int bad_strb, input int last_at);
        exp_write(id, addr, len, burst, base, bad_strb, last_at);
        aw_phase(id, addr, len, burst);
        w_phase(len, base, bad_strb, last_at);
        drain(1'b0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input bit toggle);
        exp_read(id, addr, len, burst);
        ar_phase(id, addr, len, burst);
        drain(toggle);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        ram_exp_t e;
        r_exp_t   r;
        b_exp_t   b;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (ram_en) begin
                if (ram_q.size() == 0) check("ram_extra", ram_en, 0);
                else begin
                    e = ram_q.pop_front();
                    check("ram_addr", ram_addr, e.addr);
                    check("ram_we", ram_we, e.we);
                    if (e.we) check("ram_wdata", ram_wdata, e.wdata);
                end
            end
            if (rvalid && hold_pend) check("r_hold", {rid, rresp, rlast, rdata}, hold_val);
            hold_pend = rvalid && !rready;
            hold_val  = {25'd0, rid, rresp, rlast, rdata};
            if (rvalid && rready) begin
                if (r_q.size() == 0) check("r_extra", rvalid, 0);
                else begin
                    r = r_q.pop_front();
                    check("rdata", rdata, r.data);
                    check("rlast", rlast, r.last);
                    check("rresp", rresp, r.resp);
                    check("rid", rid, r.id);
                end
            end
            if (bvalid && bready) begin
                if (b_q.size() == 0) check("b_extra", bvalid, 0);
                else begin
                    b = b_q.pop_front();
                    check("bresp", bresp, b.resp);
                    check("bid", bid, b.id);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; hold_pend = 1'b0; hold_val = '0;
        awid = 0; awaddr = 0; awlen = 0; awburst = 2'b01; awvalid = 1'b0;
        arid = 0; araddr = 0; arlen = 0; arburst = 2'b01; arvalid = 1'b0;
        wdata = 0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'hC0DE_0000 | 32'(i);
            model[i] = 32'hC0DE_0000 | 32'(i);
        end

        // Reset with both address channels already requesting.
        exp_write(4'd1, 32'h40, 0, 2'b01, 32'h1111_0000, -1, -1);
        exp_read(4'd2, 32'h40, 0, 2'b01);
        awid = 4'd1; awaddr = 32'h40; awlen = 0; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'd2; araddr = 32'h40; arlen = 0; arburst = 2'b01; arvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_resp_ids", {bid, rid, bresp, rresp, rlast}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ram_en_we", {ram_en, ram_we}, 0);
        rst = 1'b0;

        // First contention out of reset: write wins.
        @(negedge clk);
        check("arb1_awready", awready, 1);
        check("arb1_arready", arready, 0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        w_phase(0, 32'h1111_0000, -1, -1);
        ar_phase(4'd2, 32'h40, 0, 2'b01);
        drain(1'b0);

        // Second contention: read wins.
        exp_read(4'd3, 32'h44, 0, 2'b01);
        exp_write(4'd4, 32'h44, 0, 2'b01, 32'h4444_0000, -1, -1);
        awid = 4'd4; awaddr = 32'h44; awlen = 0; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'd3; araddr = 32'h44; arlen = 0; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        check("arb2_arready", arready, 1);
        check("arb2_awready", awready, 0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        aw_phase(4'd4, 32'h44, 0, 2'b01);
        w_phase(0, 32'h4444_0000, -1, -1);
        drain(1'b0);

        // Single write then readback.
        do_write(4'd5, 32'h10, 0, 2'b01, 32'hDEAD_BEEF, -1, -1);
        do_read(4'd6, 32'h10, 0, 2'b01, 1'b0);

        // INCR read: first rvalid two cycles after the AR handshake cycle, then back-to-back.
        exp_read(4'd7, 32'h0, 3, 2'b01);
        ar_phase(4'd7, 32'h0, 3, 2'b01);
        check("rd_lat_t1", rvalid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rd_lat_beat", rvalid, 1);
        end
        @(posedge clk); #1;
        check("rd_lat_end", rvalid, 0);
        drain(1'b0);

        // INCR read with rready stalls.
        do_read(4'd8, 32'h20, 5, 2'b01, 1'b1);

        // WRAP write at word 6: 6,7,4,5; readback of words 4..7.
        do_write(4'd9, 32'h18, 3, 2'b10, 32'hA000_0000, -1, -1);
        do_read(4'd10, 32'h10, 3, 2'b01, 1'b0);

        // FIXED read: word 2 three times.
        do_read(4'd11, 32'h8, 2, 2'b00, 1'b0);

        // Early wlast, then a partial-strobe beat; both SLVERR, only the strobe beat unwritten.
        do_write(4'd12, 32'h80, 2, 2'b01, 32'h5500_0000, -1, 1);
        do_write(4'd13, 32'h90, 2, 2'b01, 32'h6600_0000, 1, -1);
        do_read(4'd14, 32'h80, 2, 2'b01, 1'b0);
        do_read(4'd15, 32'h90, 2, 2'b01, 1'b1);

        // Word index 256 of a 256-word RAM.
        do_read(4'd1, 32'h400, 0, 2'b01, 1'b0);

        // Reset in the middle of an INCR read.
        exp_read(4'd2, 32'h0, 7, 2'b01);
        ar_phase(4'd2, 32'h0, 7, 2'b01);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rlast_rdata", {rlast, rdata}, 0);
        check("mid_rst_others", {bvalid, wready, ram_en}, 0);
        ram_q.delete(); r_q.delete(); b_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        do_read(4'd3, 32'h10, 0, 2'b01, 1'b0);
        do_write(4'd4, 32'h30, 1, 2'b01, 32'h7700_0000, -1, -1);
        do_read(4'd5, 32'h30, 1, 2'b01, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queues_empty", 64'(ram_q.size() + r_q.size() + b_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
